call_issuer: RTL
================

Name: call_issuer

Overview:
- Initiator side of the eBPF helper-call bus. The execution core hands it a CALL instruction (helper id plus R1–R5).
- It drives func/stb/r1–r5 toward the helper-call responder, holds stb until ack, then returns the result to the core as R0 with status flags.
- Adds a timeout watchdog and a mandatory stb-low gap between calls, so the responder never sees one strobe as two calls.

Parameters:
- TIMEOUT_CYCLES, 64: max cycles stb may stay high without ack; 0 disables the timeout.
- ERR_RET, 64'hFFFF_FFFF_FFFF_FFEA: R0 value returned on err or timeout (-EINVAL).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- call_req  in  1  core requests a helper call
- call_ready  out  1  high in IDLE; request accepted when call_req && call_ready
- call_imm  in  32  helper id from CALL immediate
- in_r1..in_r5  in  64 each  argument registers from core
- done  out  1  one-cycle pulse, call finished
- r0  out  64  call result, valid from done onward until next done
- call_err  out  1  qualifies done: responder err or timeout
- call_timeout  out  1  qualifies done: timeout occurred
- func  out  64  helper id to responder, {32'h0, call_imm}
- stb  out  1  call strobe to responder
- r1..r5  out  64 each  latched arguments to responder
- ret  in  64  responder result
- ack  in  1  responder completion pulse
- err  in  1  responder error, valid with ack

Behaviour:
- Reset (rst_n low at a clk edge):
  - state IDLE; func, r1–r5, r0 = 0; done, call_err, call_timeout = 0; timeout counter = 0.
  - stb low from that edge. Reset overrides all other events.
- State machine: IDLE, ISSUE, GAP.
- IDLE:
  - call_ready = 1.
  - On accept: latch func = {32'h0, call_imm} and r1–r5 = in_r1–in_r5; clear counter; go to ISSUE.
  - ack/err arriving in IDLE are ignored.
- ISSUE:
  - stb = 1 && !ack. This is a combinational gate, so stb is already low during the cycle ack is high and the responder never samples stb in its ack cycle.
  - func and r1–r5 are held stable throughout.
  - Counter increments each ISSUE cycle.
- ISSUE exit on ack sampled high:
  - r0 <= (err ? ERR_RET : ret); call_err <= err; call_timeout <= 0; done <= 1; go to GAP.
- ISSUE exit on timeout (TIMEOUT_CYCLES != 0, counter == TIMEOUT_CYCLES-1, no ack):
  - r0 <= ERR_RET; call_err <= 1; call_timeout <= 1; done <= 1; go to GAP.
  - stb is therefore high for exactly TIMEOUT_CYCLES cycles.
- ack and timeout in the same cycle: ack wins, normal completion.
- GAP:
  - stb = 0, call_ready = 0, for exactly one cycle, then go to IDLE.
  - A late ack in GAP is ignored and does not alter r0 or the flags.
- Flag timing: done is a single-cycle pulse (high in the first GAP cycle). call_err and call_timeout hold until the next done.
- Latency: accept at edge E0 → stb high in cycle E0+1.
  - Responder acking N cycles after first seeing stb gives done N+1 cycles after E0+1.
  - Minimum back-to-back spacing: accept, ≥1 ISSUE, GAP, IDLE.
- call_req while not ready: ignored, not queued. The core must hold call_req.
- Reset mid-call: the call is abandoned, no done pulse. The responder sees stb drop and returns to idle on its own.

Test Plan:
- LED call: call_imm=0xFF000001, in_r1=5, responder acks on 2nd stb cycle with ret=0x1234 → stb high exactly 1 visible cycle, done pulse, r0=0x1234, call_err=0.
- Store then read:
  - call_imm=0xFF000002, in_r1=3, in_r2=0xDEADBEEF, ack after 3 stb cycles → done, call_err=0.
  - Then call_imm=0xFF000003, in_r1=3 → r0=0xDEADBEEF.
  - Check stb low ≥1 cycle between the calls and func/r1–r5 stable while stb high.
- Unknown id: call_imm=0x1, responder returns ack+err → done, call_err=1, call_timeout=0, r0=0xFFFF_FFFF_FFFF_FFEA.
- Timeout: TIMEOUT_CYCLES=8, responder never acks → stb high exactly 8 cycles, done, call_err=1, call_timeout=1, r0=ERR_RET, call_ready after 1-cycle GAP.
- Reset mid-call: rst_n low during ISSUE cycle 2 → stb low from that edge, no done, all outputs 0, call_ready=1 the cycle after rst_n returns high; new call then completes normally.
- Races:
  - call_req held high continuously → second call accepted only in IDLE after GAP.
  - ack coinciding with counter == TIMEOUT_CYCLES-1 → normal completion, call_timeout=0.
  - Spurious ack in IDLE/GAP → no done, r0 unchanged.

Source files
------------

// File: rtl/call_issuer.sv
// Initiator side of the eBPF helper-call bus: latches a CALL, strobes the responder
// until ack or timeout, returns R0 with status flags, then inserts one stb-low gap cycle.
module call_issuer #(
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [63:0] ERR_RET        = 64'hFFFF_FFFF_FFFF_FFEA
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        call_req,
  output logic        call_ready,
  input  logic [31:0] call_imm,
  input  logic [63:0] in_r1,
  input  logic [63:0] in_r2,
  input  logic [63:0] in_r3,
  input  logic [63:0] in_r4,
  input  logic [63:0] in_r5,
  output logic        done,
  output logic [63:0] r0,
  output logic        call_err,
  output logic        call_timeout,
  output logic [63:0] func,
  output logic        stb,
  output logic [63:0] r1,
  output logic [63:0] r2,
  output logic [63:0] r3,
  output logic [63:0] r4,
  output logic [63:0] r5,
  input  logic [63:0] ret,
  input  logic        ack,
  input  logic        err
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             accept, fin_ack, fin_to;

  function automatic logic [63:0] sel_result(input logic fail, input logic [63:0] val);
    return fail ? ERR_RET : val;
  endfunction

  // stb is gated by ack combinationally so the responder never sees stb in its ack cycle
  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    fin_ack    = 1'b0;
    fin_to     = 1'b0;
    stb        = 1'b0;
    call_ready = 1'b0;
    case (state)
      IDLE: begin
        call_ready = 1'b1;
        if (call_req) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        stb = !ack;
        if (ack) begin
          fin_ack   = 1'b1;
          state_nxt = GAP;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST)) begin
          fin_to    = 1'b1;
          state_nxt = GAP;
        end
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Call registers and result stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt          <= '0;
      func         <= '0;
      r1           <= '0;
      r2           <= '0;
      r3           <= '0;
      r4           <= '0;
      r5           <= '0;
      r0           <= '0;
      done         <= 1'b0;
      call_err     <= 1'b0;
      call_timeout <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        func <= {32'h0, call_imm};
        r1   <= in_r1;
        r2   <= in_r2;
        r3   <= in_r3;
        r4   <= in_r4;
        r5   <= in_r5;
        cnt  <= '0;
      end else if (state == ISSUE) begin
        cnt <= cnt + 1'b1;
      end
      if (fin_ack) begin
        r0           <= sel_result(err, ret);
        call_err     <= err;
        call_timeout <= 1'b0;
        done         <= 1'b1;
      end else if (fin_to) begin
        r0           <= sel_result(1'b1, ret);
        call_err     <= 1'b1;
        call_timeout <= 1'b1;
        done         <= 1'b1;
      end
    end
  end

endmodule
